// File: rtl/compound_accumulator_pkg.sv
// Shared request/result word types and the accumulator's private FSM types.
// The shared package comes first so every later file can import it.
package shared_types_pkg;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } mode_e;

    typedef struct packed {
        mode_e              mode;
        logic signed [31:0] x;
        logic               y;
    } CompoundType;

endpackage

package compound_accumulator_types;

    typedef enum logic {
        RECV = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [7:0] COUNT_MAX = 8'hFF;

endpackage

// File: rtl/compound_accumulator_if.sv
// Request/result handshake bundle between a producer/consumer and the accumulator.
interface compound_accumulator_if;
    import shared_types_pkg::*;

    CompoundType c_in;
    logic        c_in_sync;
    logic        c_in_notify;
    CompoundType c_out;
    logic        c_out_sync;
    logic        c_out_notify;
    logic [7:0]  acc_count;

    modport slave (
        input  c_in, c_in_sync, c_out_sync,
        output c_in_notify, c_out, c_out_notify, acc_count
    );

    modport master (
        output c_in, c_in_sync, c_out_sync,
        input  c_in_notify, c_out, c_out_notify, acc_count
    );

endinterface

// File: rtl/compound_acc_alu.sv
// Combinational 32-bit wrapping adder with signed-overflow detect.
module compound_acc_alu (
    input  logic signed [31:0] acc,
    input  logic signed [31:0] x,
    output logic signed [31:0] sum,
    output logic               ovf_now
);

    always_comb begin
        sum     = acc + x;
        // Overflow only when both operands share a sign the result lacks.
        ovf_now = (acc[31] == x[31]) && (sum[31] != acc[31]);
    end

endmodule

// File: rtl/compound_accumulator.sv
// Signed accumulator: writes add/load, reads return {acc, ovf} through a
// two-state RECV/SEND handshake, optionally clearing when the result is taken.
module compound_accumulator
    import shared_types_pkg::*;
    import compound_accumulator_types::*;
(
    input  logic                        clk,
    input  logic                        rst,
    compound_accumulator_if.slave       bus
);

    state_e             state;
    state_e             state_next;
    logic               in_notify;
    logic               out_notify;
    logic               in_fire;
    logic               out_fire;
    logic signed [31:0] acc;
    logic signed [31:0] sum;
    logic               ovf;
    logic               ovf_now;
    logic               clr_on_take;
    logic [7:0]         acc_count_q;
    CompoundType        c_out_q;

    compound_acc_alu u_alu (
        .acc     (acc),
        .x       (bus.c_in.x),
        .sum     (sum),
        .ovf_now (ovf_now)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RECV;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_notify  = 1'b0;
        out_notify = 1'b0;
        unique case (state)
            RECV: begin
                in_notify = 1'b1;
                if (bus.c_in_sync && bus.c_in.mode == MODE_READ) state_next = SEND;
            end
            SEND: begin
                out_notify = 1'b1;
                if (bus.c_out_sync) state_next = RECV;
            end
            default: state_next = RECV;
        endcase
    end

    assign in_fire  = in_notify  & bus.c_in_sync;
    assign out_fire = out_notify & bus.c_out_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            ovf         <= 1'b0;
            acc_count_q <= '0;
            clr_on_take <= 1'b0;
            c_out_q     <= '{mode: MODE_READ, x: '0, y: 1'b0};
        end else begin
            if (in_fire) begin
                if (bus.c_in.mode == MODE_WRITE) begin
                    // y=1 restarts the running sum; y=0 accumulates with sticky overflow.
                    if (bus.c_in.y) begin
                        acc <= bus.c_in.x;
                        ovf <= 1'b0;
                    end else begin
                        acc <= sum;
                        ovf <= ovf | ovf_now;
                    end
                    if (acc_count_q != COUNT_MAX) acc_count_q <= acc_count_q + 8'd1;
                end else begin
                    c_out_q     <= '{mode: MODE_READ, x: acc, y: ovf};
                    clr_on_take <= bus.c_in.y;
                end
            end
            if (out_fire && clr_on_take) begin
                acc         <= '0;
                ovf         <= 1'b0;
                acc_count_q <= '0;
            end
        end
    end

    assign bus.c_in_notify  = in_notify;
    assign bus.c_out_notify = out_notify;
    assign bus.c_out        = c_out_q;
    assign bus.acc_count    = acc_count_q;

endmodule

// File: tb/tb_compound_accumulator.sv
// Directed-vector bench for compound_accumulator; inputs change on negedge,
// outputs are sampled on negedge.
module tb_compound_accumulator;
    import shared_types_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    compound_accumulator_if bus ();

    compound_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst            = 1'b0;
        bus.c_in_sync  = 1'b0;
        bus.c_out_sync = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_write(input logic [31:0] x, input logic y);
        bus.c_in      = '{mode: MODE_WRITE, x: x, y: y};
        bus.c_in_sync = 1'b1;
        @(negedge clk);
        bus.c_in_sync = 1'b0;
    endtask

    task automatic issue_read(input logic y);
        bus.c_in      = '{mode: MODE_READ, x: '0, y: y};
        bus.c_in_sync = 1'b1;
        @(negedge clk);
        bus.c_in_sync = 1'b0;
    endtask

    // Read, check the result at N+1, take it, and check the turnaround.
    task automatic read_take(input string tag, input logic y,
                             input logic [31:0] exp_x, input logic exp_ovf);
        issue_read(y);
        check({tag, ".out_notify"}, 32'(bus.c_out_notify), 32'd1);
        check({tag, ".in_notify"},  32'(bus.c_in_notify),  32'd0);
        check({tag, ".mode"},       32'(bus.c_out.mode),   32'(MODE_READ));
        check({tag, ".x"},          bus.c_out.x,           exp_x);
        check({tag, ".y"},          32'(bus.c_out.y),      32'(exp_ovf));
        bus.c_out_sync = 1'b1;
        @(negedge clk);
        bus.c_out_sync = 1'b0;
        check({tag, ".back_in_notify"},  32'(bus.c_in_notify),  32'd1);
        check({tag, ".back_out_notify"}, 32'(bus.c_out_notify), 32'd0);
        check({tag, ".hold_x"},          bus.c_out.x,           exp_x);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        bus.c_in       = '{mode: MODE_READ, x: '0, y: 1'b0};
        bus.c_in_sync  = 1'b0;
        bus.c_out_sync = 1'b0;
        apply_reset();

        check("rst.in_notify",  32'(bus.c_in_notify),  32'd1);
        check("rst.out_notify", 32'(bus.c_out_notify), 32'd0);
        check("rst.count",      32'(bus.acc_count),    32'd0);
        check("rst.x",          bus.c_out.x,           32'd0);
        check("rst.y",          32'(bus.c_out.y),      32'd0);

        // Basic sum, then a repeat read shows acc untouched by a y=0 take.
        do_write(32'd5, 1'b0);
        do_write(32'd7, 1'b0);
        read_take("sum", 1'b0, 32'd12, 1'b0);
        check("sum.count", 32'(bus.acc_count), 32'd2);
        read_take("sum_again", 1'b0, 32'd12, 1'b0);
        check("sum_again.count", 32'(bus.acc_count), 32'd2);

        // Positive overflow, then a load clears ovf.
        apply_reset();
        do_write(32'h7FFF_FFFF, 1'b0);
        do_write(32'd1, 1'b0);
        read_take("ovf_pos", 1'b0, 32'h8000_0000, 1'b1);
        do_write(32'd3, 1'b1);
        read_take("load", 1'b0, 32'd3, 1'b0);
        check("load.count", 32'(bus.acc_count), 32'd3);

        // Negative overflow and a mixed-sign add that must not flag.
        apply_reset();
        do_write(32'h8000_0000, 1'b1);
        do_write(32'hFFFF_FFFF, 1'b0);
        read_take("ovf_neg", 1'b0, 32'h7FFF_FFFF, 1'b1);
        apply_reset();
        do_write(32'hFFFF_FFFB, 1'b0);
        do_write(32'd3, 1'b0);
        read_take("mixed", 1'b0, 32'hFFFF_FFFE, 1'b0);

        // Read-and-clear.
        apply_reset();
        do_write(32'd4, 1'b0);
        do_write(32'd5, 1'b0);
        read_take("clr", 1'b1, 32'd9, 1'b0);
        check("clr.count", 32'(bus.acc_count), 32'd0);
        read_take("after_clr", 1'b0, 32'd0, 1'b0);

        // Stall in SEND while the producer keeps offering writes.
        do_write(32'd2, 1'b0);
        issue_read(1'b0);
        bus.c_in      = '{mode: MODE_WRITE, x: 32'd100, y: 1'b0};
        bus.c_in_sync = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall.in_notify",  32'(bus.c_in_notify),  32'd0);
            check("stall.out_notify", 32'(bus.c_out_notify), 32'd1);
            check("stall.x",          bus.c_out.x,           32'd2);
        end
        bus.c_in_sync  = 1'b0;
        bus.c_out_sync = 1'b1;
        @(negedge clk);
        bus.c_out_sync = 1'b0;
        check("stall.count", 32'(bus.acc_count), 32'd1);
        read_take("stall_after", 1'b0, 32'd2, 1'b0);

        // Count saturation.
        apply_reset();
        for (int i = 0; i < 300; i++) do_write(32'd1, 1'b0);
        check("sat.count", 32'(bus.acc_count), 32'd255);
        read_take("sat", 1'b0, 32'd300, 1'b0);

        // Asynchronous reset in the middle of SEND.
        do_write(32'd6, 1'b0);
        issue_read(1'b0);
        check("midrst.pre_out_notify", 32'(bus.c_out_notify), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst.out_notify", 32'(bus.c_out_notify), 32'd0);
        check("midrst.in_notify",  32'(bus.c_in_notify),  32'd1);
        check("midrst.x",          bus.c_out.x,           32'd0);
        check("midrst.y",          32'(bus.c_out.y),      32'd0);
        check("midrst.mode",       32'(bus.c_out.mode),   32'(MODE_READ));
        check("midrst.count",      32'(bus.acc_count),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_write(32'd9, 1'b0);
        read_take("first_after_rst", 1'b0, 32'd9, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/compound_accumulator.md
COMPOUND_ACCUMULATOR -- requirements
Module: compound_accumulator

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port c_in, input, CompoundType: request word. Fields: mode (read/write), x (32-bit signed), y (1 bit).
REQ-004 SHALL have port c_in_sync, input, 1 bit: producer offers c_in this cycle.
REQ-005 SHALL have port c_in_notify, output, 1 bit: block ready to accept c_in.
REQ-006 SHALL have port c_out, output, CompoundType: result word.
REQ-007 SHALL have port c_out_sync, input, 1 bit: consumer takes c_out this cycle.
REQ-008 SHALL have port c_out_notify, output, 1 bit: c_out valid.
REQ-009 SHALL have port acc_count, output, 8 bits: number of write requests accumulated since last clear.

Function
REQ-010 SHALL complete a transfer only in a cycle where notify and sync are both 1 on the same port; a sync with notify=0 SHALL be ignored.
REQ-011 SHALL implement a two-state FSM: RECV (c_in_notify=1, c_out_notify=0) and SEND (c_in_notify=0, c_out_notify=1).
REQ-012 In RECV, an accepted write with y=0 SHALL update acc to acc+x (32-bit two's-complement wrap) and stay in RECV.
REQ-013 In RECV, an accepted write with y=1 SHALL load acc with x, clear ovf, then count the write; it stays in RECV.
REQ-014 SHALL set sticky ovf when a signed add overflows (operands same sign, result sign differs); ovf holds until cleared.
REQ-015 SHALL increment acc_count on every accepted write, saturating at 255.
REQ-016 In RECV, an accepted read SHALL register c_out = {mode=read, x=acc, y=ovf} and move to SEND.
REQ-017 After a read accepted at cycle N, c_out SHALL be valid with c_out_notify=1 from cycle N+1.
REQ-018 In SEND, c_out and c_out_notify SHALL hold stable until c_out_sync=1.
REQ-019 On c_out_sync in SEND, the FSM SHALL return to RECV next cycle with c_in_notify=1 (one-cycle turnaround, no bubble beyond it).
REQ-020 If the read that caused SEND had y=1, SHALL clear acc, ovf and acc_count in the same cycle c_out is taken; c_out still carries the pre-clear values.
REQ-021 In RECV, c_out SHALL hold its last sent value.

Reset
REQ-022 Asserting rst (low) SHALL force immediately, regardless of clk: state=RECV, acc=0, ovf=0, acc_count=0, c_out.mode=read, c_out.x=0, c_out.y=0, c_in_notify=1, c_out_notify=0.
REQ-023 Reset asserted during SEND SHALL drop the pending result without completing a transfer.
REQ-024 The first accepted transfer SHALL be possible in the first rising edge after rst deasserts.

Structure
REQ-025 The FSM state enum (RECV, SEND) SHALL live in package compound_accumulator_types.
REQ-026 CompoundType and its mode enum SHALL come from the existing shared types package, not be redefined.
REQ-027 The add/overflow datapath SHALL be one combinational sub-module, compound_acc_alu (in: acc, x; out: sum, ovf_now).

Verification
REQ-028 Reset, write x=5, write x=7, read y=0 -> c_out={read,12,0} at N+1; acc_count=2; acc unchanged after take.
REQ-029 Write x=0x7FFFFFFF, write x=1, read -> c_out.x=0x80000000, c_out.y=1; a later write y=1 x=3 clears ovf, acc=3.
REQ-030 Read with y=1 after writes totalling 9 -> c_out.x=9; a following read returns x=0, acc_count=0.
REQ-031 Hold c_out_sync=0 for 10 cycles in SEND while driving c_in_sync=1 -> c_out stable, no writes absorbed, c_in_notify=0 throughout.
REQ-032 300 writes of x=1 -> acc=300, acc_count=255 (saturated).
REQ-033 Assert rst mid-SEND -> c_out_notify=0 and c_in_notify=1 asynchronously; c_out={read,0,0}, acc=0.
